// File: rtl/keypad_pkg.sv
// Shared types and key decode for the 4x4 keypad scanner.
// Column index 0 is the column driven on columnas[3].
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EVAL
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    KEY,
    GHOST
  } fclass_t;

  function automatic logic [3:0] decode_key(
    input logic [1:0] col,
    input logic [3:0] rows
  );
    logic [3:0] code;
    case ({col, rows})
      6'b00_1000: code = 4'h1;
      6'b00_0100: code = 4'h4;
      6'b00_0010: code = 4'h7;
      6'b00_0001: code = 4'hE;
      6'b01_1000: code = 4'h2;
      6'b01_0100: code = 4'h5;
      6'b01_0010: code = 4'h8;
      6'b01_0001: code = 4'h0;
      6'b10_1000: code = 4'h3;
      6'b10_0100: code = 4'h6;
      6'b10_0010: code = 4'h9;
      6'b10_0001: code = 4'hF;
      6'b11_1000: code = 4'hA;
      6'b11_0100: code = 4'hB;
      6'b11_0010: code = 4'hC;
      6'b11_0001: code = 4'hD;
      default:    code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Small synchronous FIFO for key events.
// Push while full is accepted only if a pop happens in the same cycle.
module keypad_evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with frame debounce and event FIFO.
// One frame = four column slots plus one evaluation cycle.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 2500,
  parameter int SETTLE_TICKS   = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [3:0]                    filas,
  output logic [3:0]                    columnas,
  output logic                          key_valid,
  output logic [3:0]                    key_code,
  input  logic                          key_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          irq
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TW-1:0] LAST_T   = TW'(SCAN_TICKS - 1);
  localparam logic [TW-1:0] SETTLE_T = TW'(SETTLE_TICKS);
  localparam logic [3:0]    DB       = 4'(DEBOUNCE_SCANS);

  logic [3:0]       sync1;
  logic [3:0]       sync_rows;
  state_t           state;
  state_t           state_nxt;
  logic [TW-1:0]    tick;
  logic [1:0]       col;
  logic [3:0][3:0]  snap;
  logic             last_tick;

  fclass_t          cls;
  logic [3:0]       code;
  fclass_t          last_class;
  logic [3:0]       last_code;
  logic [3:0]       stable_cnt;
  logic [3:0]       cnt_nxt;
  logic             reported;
  logic             same;
  logic             stable;

  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic             empty;

  assign last_tick = (tick == LAST_T);

  // Two-flop synchroniser for the asynchronous row lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync_rows <= '0;
    end else begin
      sync1     <= filas;
      sync_rows <= sync1;
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Scan FSM next-state logic.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SCAN;
        SCAN:    if (last_tick && col == 2'd3) state_nxt = EVAL;
        EVAL:    state_nxt = SCAN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Column drive: one-hot only while scanning.
  always_comb begin
    columnas = 4'b0000;
    if (state == SCAN) columnas = 4'b1000 >> col;
  end

  // Slot timing and per-column row snapshots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick <= '0;
      col  <= '0;
      snap <= '0;
    end else begin
      if (state == SCAN && enable) begin
        if (tick == SETTLE_T) snap[col] <= sync_rows;
        if (last_tick) begin
          tick <= '0;
          col  <= col + 2'd1;
        end else begin
          tick <= tick + 1'b1;
        end
      end else begin
        tick <= '0;
        col  <= '0;
      end
      if (!enable) snap <= '0;
    end
  end

  // Frame classification from the 16 snapshot bits.
  always_comb begin
    logic [4:0] n;
    logic [1:0] kcol;
    logic [3:0] krows;
    n     = '0;
    kcol  = '0;
    krows = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (snap[c][r]) begin
          n     = n + 5'd1;
          kcol  = 2'(c);
          krows = snap[c];
        end
      end
    end
    if (n == 5'd0)      cls = NONE;
    else if (n == 5'd1) cls = KEY;
    else                cls = GHOST;
    code = decode_key(kcol, krows);
  end

  // Debounce decision for the current frame.
  always_comb begin
    same = (cls == last_class) && (cls != KEY || code == last_code);
    if (cls == GHOST)       cnt_nxt = '0;
    else if (!same)         cnt_nxt = 4'd1;
    else if (stable_cnt >= DB) cnt_nxt = DB;
    else                    cnt_nxt = stable_cnt + 4'd1;
    stable   = (cnt_nxt == DB);
    push_req = (state == EVAL) && enable && stable
             && (cls == KEY) && !reported;
  end

  // Debounce state, cleared whenever scanning is disabled.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      last_class <= NONE;
      last_code  <= '0;
      stable_cnt <= '0;
      reported   <= 1'b0;
    end else if (state == EVAL) begin
      stable_cnt <= cnt_nxt;
      if (cls != GHOST) begin
        last_class <= cls;
        last_code  <= code;
      end
      if (stable && cls == KEY)  reported <= 1'b1;
      if (stable && cls == NONE) reported <= 1'b0;
    end
  end

  assign pop       = ~empty & key_ack;
  assign push_ok   = push_req & (~full | pop);
  assign key_valid = ~empty;

  // Push pulse and sticky drop flag; a drop beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      irq <= push_ok;
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (clr_overflow)    overflow <= 1'b0;
    end
  end

  keypad_evt_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .din   (code),
    .dout  (key_code),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl.
// Matrix model: rows = OR of pressed rows in the driven column.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  filas;
  logic [3:0]  columnas;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ack = 1'b0;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        clr_overflow = 1'b0;
  logic        irq;

  logic [3:0][3:0] pmask = '0;

  int n_chk = 0;
  int n_fail = 0;
  int irq_cnt = 0;
  int base;

  always #5 clk = ~clk;

  always_comb begin
    filas = (columnas[3] ? pmask[0] : 4'b0)
          | (columnas[2] ? pmask[1] : 4'b0)
          | (columnas[1] ? pmask[2] : 4'b0)
          | (columnas[0] ? pmask[3] : 4'b0);
  end

  always @(posedge clk) if (irq) irq_cnt <= irq_cnt + 1;

  keypad_scan_ctrl #(
    .SCAN_TICKS     (8),
    .SETTLE_TICKS   (3),
    .DEBOUNCE_SCANS (2),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .filas        (filas),
    .columnas     (columnas),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ack      (key_ack),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .irq          (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_eval();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (columnas == 4'b0000) ok = 1'b1;
    end
    chk("frame_end", 32'(ok), 32'd1);
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) wait_eval();
  endtask

  task automatic ack_one();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  logic [1:0] k_col  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
  logic [3:0] k_rows [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
  logic [3:0] k_code [4] = '{4'h1, 4'h2, 4'h3, 4'hA};

  initial begin
    logic [3:0] exp_col;

    // 1: reset state and column sequence
    enable = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_columnas", 32'(columnas), 32'h0);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      exp_col = (i < 32) ? (4'b1000 >> (i / 8)) : 4'b0000;
      chk($sformatf("scan_c%0d", i), 32'(columnas), 32'(exp_col));
    end
    @(negedge clk);
    chk("scan_repeat", 32'(columnas), 32'h8);

    // 2: single held key, one push only
    base = irq_cnt;
    pmask[0] = 4'b1000;
    wait_eval();
    @(negedge clk);
    chk("k1_irq_f1", 32'(irq), 32'h0);
    wait_eval();
    @(negedge clk);
    chk("k1_irq_f2", 32'(irq), 32'h1);
    chk("k1_valid", 32'(key_valid), 32'h1);
    chk("k1_code", 32'(key_code), 32'h1);
    chk("k1_count", 32'(fifo_count), 32'h1);
    @(negedge clk);
    chk("k1_irq_width", 32'(irq), 32'h0);
    run_frames(2);
    chk("k1_no_repeat", 32'(irq_cnt - base), 32'd1);
    pmask = '0;
    run_frames(2);
    ack_one();
    chk("k1_pop_valid", 32'(key_valid), 32'h0);
    chk("k1_pop_count", 32'(fifo_count), 32'h0);

    // 3: one-frame bounces are rejected, held D accepted
    base = irq_cnt;
    repeat (3) begin
      pmask[3] = 4'b0001;
      wait_eval();
      pmask = '0;
      wait_eval();
    end
    chk("bounce_irqs", 32'(irq_cnt - base), 32'd0);
    chk("bounce_count", 32'(fifo_count), 32'h0);
    pmask[3] = 4'b0001;
    run_frames(2);
    @(negedge clk);
    chk("kd_irq", 32'(irq), 32'h1);
    chk("kd_code", 32'(key_code), 32'hD);
    pmask = '0;
    run_frames(2);
    ack_one();
    chk("kd_pop_valid", 32'(key_valid), 32'h0);

    // 4: two keys together form a ghost frame
    base = irq_cnt;
    pmask[1] = 4'b0010;
    pmask[2] = 4'b0100;
    run_frames(4);
    chk("ghost_irqs", 32'(irq_cnt - base), 32'd0);
    chk("ghost_count", 32'(fifo_count), 32'h0);
    pmask = '0;
    run_frames(2);

    // 5: five events into a four-entry queue
    base = irq_cnt;
    for (int k = 0; k < 5; k++) begin
      pmask = '0;
      pmask[k_col[k]] = k_rows[k];
      run_frames(2);
      pmask = '0;
      run_frames(2);
    end
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_irqs", 32'(irq_cnt - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_code%0d", k), 32'(key_code), 32'(k_code[k]));
      ack_one();
    end
    chk("ovf_drained", 32'(key_valid), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'h0);

    // 6: disable mid-frame discards partial debounce
    pmask[1] = 4'b0100;
    run_frames(2);
    pmask = '0;
    run_frames(2);
    chk("en_pre_count", 32'(fifo_count), 32'd1);
    chk("en_pre_code", 32'(key_code), 32'h5);
    base = irq_cnt;
    pmask[2] = 4'b0100;
    wait_eval();
    repeat (10) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("en_off_cols", 32'(columnas), 32'h0);
    repeat (80) @(negedge clk);
    chk("en_off_idle", 32'(columnas), 32'h0);
    chk("en_off_irqs", 32'(irq_cnt - base), 32'd0);
    chk("en_off_count", 32'(fifo_count), 32'd1);
    chk("en_off_code", 32'(key_code), 32'h5);
    enable = 1'b1;
    wait_eval();
    @(negedge clk);
    chk("en_fresh_f1", 32'(irq), 32'h0);
    wait_eval();
    @(negedge clk);
    chk("en_fresh_f2", 32'(irq), 32'h1);
    chk("en_fresh_count", 32'(fifo_count), 32'd2);
    chk("en_fresh_head", 32'(key_code), 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
